// File: rtl/regfile_write_scheduler_if.sv
// Writeback bundle between the two requesters, decode, and the register-file write port.
interface regfile_write_scheduler_if #(
  parameter int unsigned DATA_W = 64
);
  logic              a_valid;
  logic [4:0]        a_reg;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [4:0]        b_reg;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              RegWrite;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic              issue_valid;
  logic [4:0]        issue_reg;
  logic              issue_ready;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              hazard1;
  logic              hazard2;
  logic              flush;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output issue_valid, issue_reg, rs1, rs2, flush,
    input  a_ready, b_ready, RegWrite, write_reg, write_data,
    input  issue_ready, hazard1, hazard2
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  issue_valid, issue_reg, rs1, rs2, flush,
    output a_ready, b_ready, RegWrite, write_reg, write_data,
    output issue_ready, hazard1, hazard2
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Round-robin arbiter for the single register-file write port, plus a
// per-register pending-write scoreboard for decode hazard checks.
module regfile_write_scheduler #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ZERO_REG = 31,
  parameter bit          RR_INIT  = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_write_scheduler_if.slave bus
);

  localparam logic [4:0] ZeroIdx = 5'(ZERO_REG);

  logic              rr_ptr_q, rr_ptr_d;
  logic              reg_write_q;
  logic [4:0]        write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic [31:0]       busy_q, busy_d;

  logic              grant_a, grant_b, contested;
  logic [4:0]        win_reg;
  logic [DATA_W-1:0] win_data;
  logic              issue_fire;

  // Arbitration: rr_ptr only breaks ties; 0 favours A, 1 favours B.
  always_comb begin
    contested = bus.a_valid && bus.b_valid;
    grant_a   = bus.a_valid && (!bus.b_valid || !rr_ptr_q);
    grant_b   = bus.b_valid && (!bus.a_valid || rr_ptr_q);
    win_reg   = grant_b ? bus.b_reg  : bus.a_reg;
    win_data  = grant_b ? bus.b_data : bus.a_data;
    rr_ptr_d  = rr_ptr_q;
    if (contested) begin
      rr_ptr_d = grant_a;  // point at the loser
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= RR_INIT;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (grant_a || grant_b) begin
        reg_write_q  <= (win_reg != ZeroIdx);
        write_reg_q  <= win_reg;
        write_data_q <= win_data;
      end else begin
        reg_write_q <= 1'b0;
      end
    end
  end

  assign bus.RegWrite   = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;

  assign bus.issue_ready = (bus.issue_reg == ZeroIdx) || !busy_q[bus.issue_reg];
  assign issue_fire      = bus.issue_valid && bus.issue_ready && (bus.issue_reg != ZeroIdx);

  // Scoreboard next state: commit clears, issue sets (set wins), flush clears all.
  always_comb begin
    busy_d = busy_q;
    if (reg_write_q) begin
      busy_d[write_reg_q] = 1'b0;
    end
    if (issue_fire) begin
      busy_d[bus.issue_reg] = 1'b1;
    end
    if (bus.flush) begin
      busy_d = '0;
    end
    busy_d[ZeroIdx] = 1'b0;
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // No bypass: hazards hold until the cycle after the register file commits.
  assign bus.hazard1 = busy_q[bus.rs1];
  assign bus.hazard2 = busy_q[bus.rs2];

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench: expected register-file writes are queued as requests are
// issued; a negedge monitor pops and compares whenever RegWrite is high.
module tb_regfile_write_scheduler;

  logic clk;
  logic rst_n;

  regfile_write_scheduler_if #(.DATA_W(64)) bus ();

  regfile_write_scheduler #(
    .DATA_W  (64),
    .ZERO_REG(31),
    .RR_INIT (1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [4:0]  r;
    logic [63:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive point: 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register-file write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.RegWrite) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got reg %0d data %0h expected no write",
                 bus.write_reg, bus.write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.write_reg !== e.r || bus.write_data !== e.d) begin
          errors++;
          $display("FAIL write: got reg %0d data %0h expected reg %0d data %0h",
                   bus.write_reg, bus.write_data, e.r, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic exp_a_win [4];
    exp_a_win = '{1'b1, 1'b0, 1'b1, 1'b0};

    bus.a_valid = 0; bus.a_reg = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_reg = 0; bus.b_data = 0;
    bus.issue_valid = 0; bus.issue_reg = 0;
    bus.rs1 = 0; bus.rs2 = 0; bus.flush = 0;

    // Reset then idle.
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("reset_regwrite", 64'(bus.RegWrite), 64'd0);
    check("reset_write_reg", 64'(bus.write_reg), 64'd0);
    check("reset_write_data", bus.write_data, 64'd0);
    check("reset_hazard1", 64'(bus.hazard1), 64'd0);
    check("reset_hazard2", 64'(bus.hazard2), 64'd0);
    for (int i = 0; i < 32; i += 9) begin
      bus.issue_reg = 5'(i);
      #1;
      check("reset_issue_ready", 64'(bus.issue_ready), 64'd1);
    end

    // Single write from A.
    step();
    bus.a_valid = 1; bus.a_reg = 5; bus.a_data = 64'hDEAD;
    exp_q.push_back('{r: 5'd5, d: 64'hDEAD});
    @(negedge clk);
    check("single_a_ready", 64'(bus.a_ready), 64'd1);
    check("single_b_ready", 64'(bus.b_ready), 64'd0);
    step();
    bus.a_valid = 0;

    // Contention: A and B both valid for 4 cycles, expect A,B,A,B.
    bus.a_valid = 1; bus.a_reg = 3; bus.a_data = 64'h33;
    bus.b_valid = 1; bus.b_reg = 4; bus.b_data = 64'h44;
    for (int i = 0; i < 4; i++) begin
      if (exp_a_win[i]) exp_q.push_back('{r: 5'd3, d: 64'h33});
      else              exp_q.push_back('{r: 5'd4, d: 64'h44});
      @(negedge clk);
      check("rr_a_ready", 64'(bus.a_ready), 64'(exp_a_win[i]));
      check("rr_b_ready", 64'(bus.b_ready), 64'(!exp_a_win[i]));
      step();
    end
    bus.a_valid = 0; bus.b_valid = 0;

    // Scoreboard RAW/WAW on reg 7, committed by B.
    bus.issue_valid = 1; bus.issue_reg = 7;
    @(negedge clk);
    check("sb_issue_ready_free", 64'(bus.issue_ready), 64'd1);
    step();
    bus.issue_valid = 0; bus.rs1 = 7;
    @(negedge clk);
    check("sb_hazard1_set", 64'(bus.hazard1), 64'd1);
    check("sb_issue_ready_waw", 64'(bus.issue_ready), 64'd0);
    step();
    bus.b_valid = 1; bus.b_reg = 7; bus.b_data = 64'h77;
    exp_q.push_back('{r: 5'd7, d: 64'h77});
    @(negedge clk);
    check("sb_b_ready", 64'(bus.b_ready), 64'd1);
    check("sb_hazard_accept_cycle", 64'(bus.hazard1), 64'd1);
    step();
    bus.b_valid = 0;
    @(negedge clk);
    check("sb_commit_regwrite", 64'(bus.RegWrite), 64'd1);
    check("sb_hazard_commit_cycle", 64'(bus.hazard1), 64'd1);
    step();
    @(negedge clk);
    check("sb_hazard_cleared", 64'(bus.hazard1), 64'd0);
    check("sb_issue_ready_again", 64'(bus.issue_ready), 64'd1);

    // Zero register: never busy, write accepted but discarded.
    step();
    bus.issue_valid = 1; bus.issue_reg = 31;
    bus.a_valid = 1; bus.a_reg = 31; bus.a_data = 64'h1234;
    @(negedge clk);
    check("zero_a_ready", 64'(bus.a_ready), 64'd1);
    check("zero_issue_ready", 64'(bus.issue_ready), 64'd1);
    step();
    bus.issue_valid = 0; bus.a_valid = 0; bus.rs1 = 31;
    @(negedge clk);
    check("zero_hazard1", 64'(bus.hazard1), 64'd0);
    check("zero_regwrite", 64'(bus.RegWrite), 64'd0);
    check("zero_write_reg", 64'(bus.write_reg), 64'd31);

    // Flush: issue 2 and 9, then flush alongside a new issue and an A write.
    step();
    bus.issue_valid = 1; bus.issue_reg = 2;
    step();
    bus.issue_reg = 9;
    step();
    bus.issue_valid = 0; bus.rs1 = 2; bus.rs2 = 9;
    @(negedge clk);
    check("flush_pre_hazard1", 64'(bus.hazard1), 64'd1);
    check("flush_pre_hazard2", 64'(bus.hazard2), 64'd1);
    step();
    bus.flush = 1; bus.issue_valid = 1; bus.issue_reg = 12;
    bus.a_valid = 1; bus.a_reg = 6; bus.a_data = 64'h66;
    exp_q.push_back('{r: 5'd6, d: 64'h66});
    @(negedge clk);
    check("flush_cycle_hazard1", 64'(bus.hazard1), 64'd1);
    check("flush_a_ready", 64'(bus.a_ready), 64'd1);
    step();
    bus.flush = 0; bus.issue_valid = 0; bus.a_valid = 0;
    @(negedge clk);
    check("flush_hazard1", 64'(bus.hazard1), 64'd0);
    check("flush_hazard2", 64'(bus.hazard2), 64'd0);
    check("flush_write_survives", 64'(bus.RegWrite), 64'd1);
    bus.rs1 = 12;
    #1;
    check("flush_beats_set", 64'(bus.hazard1), 64'd0);

    // Asynchronous reset mid-write: RegWrite drops without a clock edge.
    step();
    bus.a_valid = 1; bus.a_reg = 10; bus.a_data = 64'hAA;
    step();
    bus.a_valid = 0;
    check("async_pre_regwrite", 64'(bus.RegWrite), 64'd1);
    #2 rst_n = 0;
    #1;
    check("async_regwrite", 64'(bus.RegWrite), 64'd0);
    check("async_write_reg", 64'(bus.write_reg), 64'd0);
    step();
    rst_n = 1;
    step();

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Shares the single register-file write port between two writeback requesters: A (ALU result) and B (load result).
- Keeps a per-register pending-write scoreboard, used by decode for RAW hazard detection and WAW issue blocking.
- Sits between the writeback stage and the register file's RegWrite/write_reg/write_data inputs.
- Register 31 is the zero register: writes to it are accepted and then discarded, and it is never marked busy.

Parameters:
- DATA_W, 64, width of write data.
- ZERO_REG, 31, index of the hardwired-zero register.
- RR_INIT, 0, round-robin pointer after reset (0 = A has priority first, 1 = B has priority first).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- a_valid  input  1  requester A has a write pending
- a_reg  input  5  requester A destination register
- a_data  input  DATA_W  requester A write data
- a_ready  output  1  requester A write accepted this cycle
- b_valid  input  1  requester B has a write pending
- b_reg  input  5  requester B destination register
- b_data  input  DATA_W  requester B write data
- b_ready  output  1  requester B write accepted this cycle
- RegWrite  output  1  register-file write enable (registered)
- write_reg  output  5  register-file write index (registered)
- write_data  output  DATA_W  register-file write data (registered)
- issue_valid  input  1  decode issuing an instruction with destination issue_reg
- issue_reg  input  5  destination of issuing instruction
- issue_ready  output  1  issue permitted (no WAW conflict)
- rs1  input  5  decode source register 1
- rs2  input  5  decode source register 2
- hazard1  output  1  rs1 has a pending write
- hazard2  output  1  rs2 has a pending write
- flush  input  1  pipeline flush: clear scoreboard

Behaviour:
- Reset (rst_n=0, asynchronous):
  - RegWrite=0, write_reg=0, write_data=0.
  - busy[31:0]=0.
  - rr_ptr=RR_INIT.
- Arbitration (combinational, per cycle):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester selected by rr_ptr.
  - x_ready=1 only for the granted requester. At most one ready per cycle.
  - No other stall source: a valid requester is always granted or waiting.
- rr_ptr update: only on a contested cycle (both valid). It then points to the loser. Uncontested cycles leave it unchanged.
- Output register, on the edge where a grant occurs:
  - write_reg and write_data load the winner's reg and data.
  - RegWrite=1 if the winner's reg != ZERO_REG, else RegWrite=0.
  - With no grant: RegWrite=0, write_reg and write_data hold.
- Latency: a request accepted at edge N appears on RegWrite at cycle N+1. The register file commits it at edge N+1.
- Scoreboard busy[i]:
  - Set at the edge where issue_valid && issue_ready && issue_reg != ZERO_REG.
  - Cleared at the edge where RegWrite=1 && write_reg==i, i.e. when the register file commits.
  - Set and clear of the same index on the same edge: set wins.
  - busy[ZERO_REG] is always 0.
- issue_ready = !busy[issue_reg], or 1 if issue_reg==ZERO_REG. Combinational.
- hazard1 = busy[rs1]; hazard2 = busy[rs2]. Combinational, no bypass.
  - The hazard clears in the cycle after commit, when register-file read data is valid.
- flush:
  - Clears all busy bits at the next edge. It has priority over a simultaneous set.
  - Does not cancel an accepted write already in the output register; that write still commits.
  - Does not affect arbitration.
- Requester inputs are sampled only when ready=1. A requester must hold valid, reg and data stable until ready.
- A reset asserted mid-operation drops any in-flight write. RegWrite is forced to 0 asynchronously.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, all valid=0 -> RegWrite=0, hazard1=hazard2=0, issue_ready=1 for any issue_reg.
- Single write: a_valid=1, a_reg=5, a_data=0xDEAD for 1 cycle -> a_ready=1 that cycle; next cycle RegWrite=1, write_reg=5, write_data=0xDEAD.
- Contention and round-robin: A and B both valid for 4 cycles, regs 3/4, RR_INIT=0 -> grants alternate A,B,A,B; RegWrite sequence write_reg=3,4,3,4.
- Scoreboard RAW/WAW: issue reg 7 -> next cycle hazard1=1 with rs1=7 and issue_ready=0 for issue_reg=7; B writes reg 7 -> hazard1 stays 1 through the RegWrite cycle and drops to 0 the following cycle.
- Zero register: issue_reg=31 and a_reg=31 with data 0x1234 -> busy never set, hazard1=0 with rs1=31, a_ready=1, next cycle RegWrite=0.
- Flush and async reset: issue regs 2 and 9, assert flush for 1 cycle -> hazards clear on the next edge; separately, drop rst_n mid-write -> RegWrite=0 immediately with no clock edge.
